// File: rtl/vic20_pkg.sv
// Shared types and constants for the VIC-20 download/load controller.
package vic20_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_INJECT, S_RESET_WAIT
  } load_state_t;

  localparam logic [15:0] CART_BASE_DFLT = 16'hA000;

  // BASIC end-of-program pointers; even slots take the low byte, odd the high.
  localparam logic [7:0][15:0] INJ_ADDR = {
    16'h00AF, 16'h00AE, 16'h0032, 16'h0031,
    16'h0030, 16'h002F, 16'h002E, 16'h002D
  };

endpackage

// File: rtl/vic20_load_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees a full slot for a same-cycle push.
module load_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vic20_load_ctrl.sv
// Sequences PRG/CRT downloads into the SDRAM write port, then injects BASIC
// end pointers and optionally pulses a delayed core reset for $A000 carts.
module vic20_load_ctrl import vic20_pkg::*; #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] CART_BASE   = CART_BASE_DFLT,
  parameter int          RESET_DELAY = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic [7:0]  dl_index,
  input  logic        dl_wr,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        hdr_mode,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic        force_reset,
  output logic        busy,
  output logic [15:0] end_addr,
  output logic        overflow
);
  localparam int CW = $clog2(RESET_DELAY + 1);

  load_state_t state_q, state_d;
  logic        hdr_q, hdr_d;
  logic        auto_q, auto_d;
  logic        ovf_q, ovf_d;
  logic        frst_q, frst_d;
  logic [15:0] start_q, start_d;
  logic [15:0] end_q, end_d;
  logic [2:0]  inj_q, inj_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        f_push, f_pop, f_full, f_empty;
  logic [23:0] f_rdata;
  logic [15:0] wr_addr;
  logic        is_data, load_wr, fifo_req, inj_act, push_ok;

  load_fifo #(.DEPTH(FIFO_DEPTH), .W(24)) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .push  (f_push),
    .wdata ({wr_addr, dl_data}),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  always_comb begin
    wr_addr  = hdr_q ? (start_q + dl_addr - 16'd2) : (CART_BASE + dl_addr);
    is_data  = ~hdr_q | (dl_addr > 16'd1);
    load_wr  = (state_q == S_LOAD) & dl_wr;
    fifo_req = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && !f_empty;
    inj_act  = (state_q == S_INJECT);
    f_pop    = fifo_req & mem_ack;
    f_push   = load_wr & is_data;
    push_ok  = ~f_full | f_pop;
  end

  // Outputs are muxed straight from registered state so the FIFO head can be
  // presented the cycle after the push, and held until the ack pops it.
  always_comb begin
    mem_req  = fifo_req | inj_act;
    mem_addr = '0;
    mem_data = '0;
    if (fifo_req) begin
      mem_addr = f_rdata[23:8];
      mem_data = f_rdata[7:0];
    end else if (inj_act) begin
      mem_addr = INJ_ADDR[inj_q];
      mem_data = inj_q[0] ? end_q[15:8] : end_q[7:0];
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign end_addr    = end_q;
  assign overflow    = ovf_q;
  assign force_reset = frst_q;

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    auto_d  = auto_q;
    ovf_d   = ovf_q;
    start_d = start_q;
    end_d   = end_q;
    inj_d   = inj_q;
    cnt_d   = cnt_q;
    frst_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dl_active && dl_index != 8'd0) begin
          state_d = S_LOAD;
          hdr_d   = hdr_mode | (dl_index[4:0] == 5'd1);
          start_d = (hdr_mode | (dl_index[4:0] == 5'd1)) ? 16'd0 : CART_BASE;
          end_d   = start_d;
          auto_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_wr) begin
          if (!is_data) begin
            if (dl_addr[0]) start_d[15:8] = dl_data;
            else            start_d[7:0]  = dl_data;
            end_d = start_d;
          end else begin
            // end_addr tracks every strobe, even ones dropped on overflow
            end_d = wr_addr + 16'd1;
            if (push_ok) begin
              if (wr_addr == CART_BASE) auto_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        if (!dl_active) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (f_empty) begin
          state_d = S_INJECT;
          inj_d   = 3'd0;
        end
      end
      S_INJECT: begin
        if (mem_ack) begin
          if (inj_q == 3'd7) begin
            state_d = auto_q ? S_RESET_WAIT : S_IDLE;
            cnt_d   = '0;
          end else begin
            inj_d = inj_q + 3'd1;
          end
        end
      end
      S_RESET_WAIT: begin
        if (cnt_q == CW'(RESET_DELAY - 1)) begin
          frst_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hdr_q   <= 1'b0;
      auto_q  <= 1'b0;
      ovf_q   <= 1'b0;
      frst_q  <= 1'b0;
      start_q <= '0;
      end_q   <= '0;
      inj_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      auto_q  <= auto_d;
      ovf_q   <= ovf_d;
      frst_q  <= frst_d;
      start_q <= start_d;
      end_q   <= end_d;
      inj_q   <= inj_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
